e3_serial_mult_ctrl: RTL and testbench

Sequential controller that multiplies a DIGITS-digit Excess-3 number by a single Excess-3 digit, one digit per clock, least-significant digit first.
Drives a single-digit Excess-3 multiply-accumulate datapath, keeps the decimal carry between digits and returns a (DIGITS+1)-digit Excess-3 product.
Sits between a requester using a start/done handshake and the shared digit-multiply resource.

---
 rtl/e3_pkg.sv | 18 +
 rtl/e3_digit_mac.sv | 25 ++
 rtl/e3_serial_mult_ctrl.sv | 125 ++++++++++++
 tb/tb_e3_serial_mult_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/e3_pkg.sv
// rtl/e3_pkg.sv - shared Excess-3 constants, FSM state type and digit validity check
package e3_pkg;

  localparam logic [3:0] E3_OFFSET = 4'd3;
  localparam logic [3:0] E3_ZERO   = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  // A legal Excess-3 digit encodes 0..9, i.e. 0011..1100
  function automatic logic e3_valid(input logic [3:0] nibble);
    return (nibble >= 4'd3) && (nibble <= 4'd12);
  endfunction

endpackage

// File: rtl/e3_digit_mac.sv
// rtl/e3_digit_mac.sv - one Excess-3 digit multiply-accumulate step with decimal carry
module e3_digit_mac
  import e3_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [3:0] b,
  input  logic [3:0] carry_in,
  output logic [3:0] digit_out,
  output logic [3:0] carry_out
);

  logic [3:0] digit_bin;
  logic [3:0] b_bin;
  logic [6:0] p;

  // Strip the offset, multiply-accumulate in binary, split into decimal digit and carry
  always_comb begin
    digit_bin = digit - E3_OFFSET;
    b_bin     = b - E3_OFFSET;
    p         = {3'b000, digit_bin} * {3'b000, b_bin} + {3'b000, carry_in};
    digit_out = 4'(p % 7'd10) + E3_OFFSET;
    carry_out = 4'(p / 7'd10);
  end

endmodule

// File: rtl/e3_serial_mult_ctrl.sv
// rtl/e3_serial_mult_ctrl.sv - digit-serial Excess-3 multiplier controller (option: E3_ZERO_SKIP_EN)
module e3_serial_mult_ctrl
  import e3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [4*DIGITS-1:0]       a,
  input  logic [3:0]                b,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [4*(DIGITS+1)-1:0]   result
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [4*(DIGITS+1)-1:0] RESULT_ZERO = {(DIGITS+1){E3_ZERO}};

  state_t                    state_q, state_d;
  logic [4*DIGITS-1:0]       a_q;
  logic [3:0]                b_q;
  logic [IDX_W-1:0]          idx_q;
  logic [3:0]                carry_q;
  logic [4*(DIGITS+1)-1:0]   result_q;
  logic                      err_pend_q;

  logic                      in_valid;
  logic                      accept;
  logic                      skip;
  logic                      last_digit;
  logic [3:0]                mac_in;
  logic [3:0]                mac_digit;
  logic [3:0]                mac_carry;

  // Check every incoming nibble so a bad operand is flagged at acceptance
  always_comb begin
    in_valid = e3_valid(b);
    for (int i = 0; i < DIGITS; i++) begin
      if (!e3_valid(a[i*4 +: 4])) in_valid = 1'b0;
    end
  end

  assign accept     = (state_q == IDLE) && start;
  assign last_digit = (idx_q == LAST_IDX);
  assign mac_in     = a_q[idx_q*4 +: 4];

`ifdef E3_ZERO_SKIP_EN
  assign skip = accept && in_valid && (b == E3_ZERO);
`else
  assign skip = 1'b0;
`endif

  e3_digit_mac u_mac (
    .digit     (mac_in),
    .b         (b_q),
    .carry_in  (carry_q),
    .digit_out (mac_digit),
    .carry_out (mac_carry)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one MUL cycle per digit, then a single DONE cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = skip ? DONE : MUL;
      MUL:  if (last_digit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    err    = (state_q == DONE) && err_pend_q;
    result = result_q;
  end

  // Operand latch, digit index, decimal carry and result digits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q        <= {DIGITS{E3_ZERO}};
      b_q        <= E3_ZERO;
      idx_q      <= '0;
      carry_q    <= '0;
      err_pend_q <= 1'b0;
      result_q   <= RESULT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q        <= a;
            b_q        <= b;
            idx_q      <= '0;
            carry_q    <= '0;
            err_pend_q <= !in_valid;
            if (skip) result_q <= RESULT_ZERO;
          end
        end
        MUL: begin
          result_q[idx_q*4 +: 4] <= mac_digit;
          carry_q                <= mac_carry;
          idx_q                  <= idx_q + 1'b1;
          if (last_digit) begin
            result_q[DIGITS*4 +: 4] <= mac_carry + E3_OFFSET;
            // An invalid operand yields an Excess-3 zero product
            if (err_pend_q) result_q <= RESULT_ZERO;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_e3_serial_mult_ctrl.sv
// tb/tb_e3_serial_mult_ctrl.sv - scoreboard bench for the Excess-3 serial multiplier controller
module tb_e3_serial_mult_ctrl;

  localparam int DIGITS = 4;
  localparam int RW     = 4*(DIGITS+1);
  localparam logic [RW-1:0] ZERO_RES = {(DIGITS+1){4'b0011}};
`ifdef E3_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = DIGITS + 1;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [4*DIGITS-1:0]  a = '0;
  logic [3:0]           b = '0;
  logic                 busy, done, err;
  logic [RW-1:0]        result;

  typedef struct {
    logic [RW-1:0] res;
    logic          e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  e3_serial_mult_ctrl #(.DIGITS(DIGITS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Decimal reference: whole-number multiply, then re-encode as Excess-3
  function automatic exp_t model(input logic [4*DIGITS-1:0] av, input logic [3:0] bv);
    exp_t r;
    int val, prod;
    logic bad;
    logic [3:0] nib;
    bad = (bv < 4'd3) || (bv > 4'd12);
    val = 0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      nib = av[i*4 +: 4];
      if (nib < 4'd3 || nib > 4'd12) bad = 1'b1;
      val = val*10 + int'(nib) - 3;
    end
    prod = val * (int'(bv) - 3);
    for (int i = 0; i <= DIGITS; i++) begin
      r.res[i*4 +: 4] = 4'(prod % 10 + 3);
      prod = prod / 10;
    end
    r.e = bad;
    if (bad) r.res = ZERO_RES;
    return r;
  endfunction

  // Issue one start pulse and wait (bounded) for done; lat counts edges from start
  task automatic run_req(input logic [4*DIGITS-1:0] av, input logic [3:0] bv,
                         output int lat, output logic [RW-1:0] res, output logic e);
    a = av; b = bv; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
    end while (done !== 1'b1 && lat < 30);
    res = result;
    e = err;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if (result !== ZERO_RES) begin n_bad++; $display("FAIL reset_result: got %h expected %h", result, ZERO_RES); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat; logic [RW-1:0] res; logic e; exp_t ex;
    sb.push_back('{res: 20'h394A3, e: 1'b0});
    run_req(16'h4567, 4'h8, lat, res, e);
    ex = sb.pop_front();
    n_cmp++; if (lat !== DIGITS+1) begin n_bad++; $display("FAIL basic_latency: got %0d expected %0d", lat, DIGITS+1); end
    n_cmp++; if (res !== ex.res) begin n_bad++; $display("FAIL basic_result: got %h expected %h", res, ex.res); end
    n_cmp++; if (e !== ex.e) begin n_bad++; $display("FAIL basic_err: got %b expected %b", e, ex.e); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_pulse: got done=%b busy=%b expected 0 0", done, busy); end
    repeat (3) @(negedge clk);
    n_cmp++; if (result !== 20'h394A3) begin n_bad++; $display("FAIL basic_hold: got %h expected 394a3", result); end
  endtask

  task automatic test_saturate;
    int lat; logic [RW-1:0] res; logic e; exp_t ex;
    sb.push_back('{res: 20'hBCCC4, e: 1'b0});
    run_req(16'hCCCC, 4'hC, lat, res, e);
    ex = sb.pop_front();
    n_cmp++; if (lat !== DIGITS+1) begin n_bad++; $display("FAIL sat_latency: got %0d expected %0d", lat, DIGITS+1); end
    n_cmp++; if (res !== ex.res) begin n_bad++; $display("FAIL sat_result: got %h expected %h", res, ex.res); end
    n_cmp++; if (e !== ex.e) begin n_bad++; $display("FAIL sat_err: got %b expected %b", e, ex.e); end
    @(negedge clk);
  endtask

  task automatic test_invalid;
    int lat; logic [RW-1:0] res; logic e; exp_t ex;
    logic [4*DIGITS-1:0] av [2] = '{16'h4503, 16'h4567};
    logic [3:0]          bv [2] = '{4'h8, 4'hF};
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{res: ZERO_RES, e: 1'b1});
      run_req(av[k], bv[k], lat, res, e);
      ex = sb.pop_front();
      n_cmp++; if (lat !== DIGITS+1) begin n_bad++; $display("FAIL inv%0d_latency: got %0d expected %0d", k, lat, DIGITS+1); end
      n_cmp++; if (res !== ex.res) begin n_bad++; $display("FAIL inv%0d_result: got %h expected %h", k, res, ex.res); end
      n_cmp++; if (e !== ex.e) begin n_bad++; $display("FAIL inv%0d_err: got %b expected %b", k, e, ex.e); end
      @(negedge clk);
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL inv%0d_err_clear: got %b expected 0", k, err); end
    end
  endtask

  task automatic test_random;
    int lat; logic [RW-1:0] res; logic e; exp_t ex;
    logic [4*DIGITS-1:0] av; logic [3:0] bv;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < DIGITS; i++) av[i*4 +: 4] = 4'($urandom_range(9) + 3);
      bv = 4'($urandom_range(9) + 3);
      sb.push_back(model(av, bv));
      run_req(av, bv, lat, res, e);
      ex = sb.pop_front();
      n_cmp++; if (res !== ex.res || e !== ex.e || lat !== DIGITS+1) begin
        n_bad++; $display("FAIL rand%0d: a=%h b=%h got %h/%b/%0d expected %h/%b/%0d", k, av, bv, res, e, lat, ex.res, ex.e, DIGITS+1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored;
    int lat; int cnt0; exp_t ex;
    sb.push_back('{res: 20'h394A3, e: 1'b0});
    a = 16'h4567; b = 4'h8; start = 1'b1;
    @(negedge clk); start = 1'b0;          // T0 passed
    @(negedge clk);                        // T1 passed
    a = 16'hCCCC; b = 4'hC; start = 1'b1;
    @(negedge clk); start = 1'b0;          // T2 passed
    lat = 3;
    while (done !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
    ex = sb.pop_front();
    n_cmp++; if (lat !== DIGITS+1) begin n_bad++; $display("FAIL ign_latency: got %0d expected %0d", lat, DIGITS+1); end
    n_cmp++; if (result !== ex.res) begin n_bad++; $display("FAIL ign_result: got %h expected %h", result, ex.res); end
    @(negedge clk);
    cnt0 = done_cnt;
    repeat (10) @(negedge clk);
    n_cmp++; if (done_cnt !== cnt0) begin n_bad++; $display("FAIL ign_no_queue: got %0d extra done expected 0", done_cnt - cnt0); end
  endtask

  task automatic test_reset_abort;
    int cnt0;
    a = 16'hCCCC; b = 4'hC; start = 1'b1;
    @(negedge clk); start = 1'b0;          // T0 passed
    @(negedge clk);                        // T1 passed
    rst_n = 1'b0;
    @(negedge clk);                        // reset sampled at T2
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (result !== ZERO_RES) begin n_bad++; $display("FAIL abort_result: got %h expected %h", result, ZERO_RES); end
    rst_n = 1'b1;
    cnt0 = done_cnt;
    repeat (10) @(negedge clk);
    n_cmp++; if (done_cnt !== cnt0) begin n_bad++; $display("FAIL abort_no_done: got %0d done expected 0", done_cnt - cnt0); end
  endtask

  task automatic test_zero_b;
    int lat; logic [RW-1:0] res; logic e; exp_t ex;
    sb.push_back('{res: ZERO_RES, e: 1'b0});
    run_req(16'h4567, 4'h3, lat, res, e);
    ex = sb.pop_front();
    n_cmp++; if (lat !== ZLAT) begin n_bad++; $display("FAIL zero_latency: got %0d expected %0d", lat, ZLAT); end
    n_cmp++; if (res !== ex.res) begin n_bad++; $display("FAIL zero_result: got %h expected %h", res, ex.res); end
    n_cmp++; if (e !== ex.e) begin n_bad++; $display("FAIL zero_err: got %b expected %b", e, ex.e); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int t; int t1; int t2; int drop_at; exp_t ex;
    t = 0; t1 = -1; t2 = -1; drop_at = -1;
    sb.push_back(model(16'h4567, 4'h8));
    sb.push_back(model(16'h5A3C, 4'h7));
    a = 16'h4567; b = 4'h8; start = 1'b1;
    while (t2 < 0 && t < 40) begin
      @(negedge clk);
      t++;
      if (t == 1) begin a = 16'h5A3C; b = 4'h7; end
      if (t == drop_at) start = 1'b0;
      if (done === 1'b1) begin
        ex = sb.pop_front();
        n_cmp++; if (result !== ex.res || err !== ex.e) begin
          n_bad++; $display("FAIL b2b_result: got %h/%b expected %h/%b", result, err, ex.res, ex.e);
        end
        if (t1 < 0) begin t1 = t; drop_at = t + 2; end
        else t2 = t;
      end
    end
    start = 1'b0;
    n_cmp++; if (t2 - t1 !== DIGITS+2) begin n_bad++; $display("FAIL b2b_spacing: got %0d expected %0d", t2 - t1, DIGITS+2); end
    n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL b2b_drain: got %0d pending expected 0", sb.size()); end
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_invalid();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_zero_b();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
